lane_occupancy_tracker: RTL and testbench

- Produces the 8-bit `sensors` demand vector consumed by the intersection phase controller.
- Each lane keeps a vehicle count. Raw detector arrival strobes increment the count. The count drains while that lane's phase holds the one-hot `traffic` grant.
- A sensor bit is high while its lane has any waiting vehicle.
- Sits between the loop-detector front end and the phase controller, closing the sensor/grant loop.

---
 rtl/lane_occupancy_tracker_pkg.sv | 24 ++
 rtl/lane_occupancy_tracker_if.sv | 22 ++
 rtl/lane_queue_counter.sv | 47 ++++
 rtl/lane_occupancy_tracker.sv | 68 ++++++
 tb/tb_lane_occupancy_tracker.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/lane_occupancy_tracker_pkg.sv
// Shared constants and helpers for the lane occupancy tracker.
package lane_occupancy_tracker_pkg;

    localparam int NUM_LANES  = 8;
    localparam int NUM_PHASES = 4;

    typedef enum logic [3:0] {
        PH_NONE = 4'b0000,
        PH_T1   = 4'b0001,
        PH_T2   = 4'b0010,
        PH_T3   = 4'b0100,
        PH_T4   = 4'b1000
    } phase_e;

    // Lanes 2k-1 and 2k share phase k.
    function automatic int lane_phase(input int lane);
        return (lane + 1) / 2;
    endfunction

    function automatic logic is_onehot(input logic [NUM_PHASES-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/lane_occupancy_tracker_if.sv
// Detector/grant/sensor bundle between the front end, the tracker and the phase controller.
interface lane_occupancy_tracker_if #(
    parameter int unsigned CNT_W = 6
);
    logic [8:1]         arrive;
    logic [4:1]         traffic;
    logic               ovf_clr;
    logic [8:1]         sensors;
    logic [8:1]         overflow;
    logic [8*CNT_W-1:0] queue_count;
    logic               illegal_grant;

    modport master (
        output arrive, traffic, ovf_clr,
        input  sensors, overflow, queue_count, illegal_grant
    );

    modport slave (
        input  arrive, traffic, ovf_clr,
        output sensors, overflow, queue_count, illegal_grant
    );
endinterface

// File: rtl/lane_queue_counter.sv
// Per-lane saturating vehicle counter with sticky overflow flag.
module lane_queue_counter #(
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arrive,
    input  logic             dec,
    input  logic             ovf_clr,
    output logic [CNT_W-1:0] count,
    output logic             nonempty,
    output logic             overflow
);
    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [CNT_W-1:0] count_d;
    logic             dec_eff;
    logic             ovf_set;

    always_comb begin
        dec_eff = dec && (count != '0);
        count_d = count;
        ovf_set = 1'b0;
        // Simultaneous arrival and departure cancel, so saturation cannot flag then.
        if (arrive && !dec_eff) begin
            if (count == CntMax) begin
                ovf_set = 1'b1;
            end else begin
                count_d = count + 1'b1;
            end
        end else if (!arrive && dec_eff) begin
            count_d = count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= '0;
            nonempty <= 1'b0;
            overflow <= 1'b0;
        end else begin
            count    <= count_d;
            nonempty <= (count_d != '0);
            overflow <= ovf_set | (overflow & ~ovf_clr);
        end
    end
endmodule

// File: rtl/lane_occupancy_tracker.sv
// Tracks per-lane vehicle queues from arrival strobes and drains them under the phase grant.
module lane_occupancy_tracker
    import lane_occupancy_tracker_pkg::*;
#(
    parameter int unsigned CNT_W        = 6,
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    lane_occupancy_tracker_if.slave  bus
);
    localparam int unsigned TMR_W = 6;

    logic [4:1]       prev_traffic_q;
    logic [TMR_W-1:0] timer_q;
    logic [TMR_W-1:0] timer_d;
    logic [TMR_W-1:0] t_eff;
    logic             valid;
    logic             tick;
    logic             illegal_grant_q;

    logic [CNT_W-1:0]   lane_count [1:NUM_LANES];
    logic [NUM_LANES:1] lane_nonempty;
    logic [NUM_LANES:1] lane_overflow;

    // A grant that differs from last cycle's is its first cycle, counted as 1.
    always_comb begin
        valid   = is_onehot(bus.traffic);
        t_eff   = (bus.traffic != prev_traffic_q) ? TMR_W'(1) : timer_q + 1'b1;
        tick    = valid && (t_eff == TMR_W'(DRAIN_CYCLES));
        timer_d = (!valid || tick) ? '0 : t_eff;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_traffic_q  <= '0;
            timer_q         <= '0;
            illegal_grant_q <= 1'b0;
        end else begin
            prev_traffic_q  <= bus.traffic;
            timer_q         <= timer_d;
            illegal_grant_q <= (bus.traffic != '0) && !valid;
        end
    end

    for (genvar i = 1; i <= NUM_LANES; i++) begin : g_lane
        localparam int Ph = lane_phase(i);

        lane_queue_counter #(
            .CNT_W (CNT_W)
        ) u_counter (
            .clk      (clk),
            .rst      (rst),
            .arrive   (bus.arrive[i]),
            .dec      (tick && bus.traffic[Ph]),
            .ovf_clr  (bus.ovf_clr),
            .count    (lane_count[i]),
            .nonempty (lane_nonempty[i]),
            .overflow (lane_overflow[i])
        );

        assign bus.queue_count[i*CNT_W-1 -: CNT_W] = lane_count[i];
    end

    assign bus.sensors       = lane_nonempty;
    assign bus.overflow      = lane_overflow;
    assign bus.illegal_grant = illegal_grant_q;
endmodule

// File: tb/tb_lane_occupancy_tracker.sv
// Self-checking bench: directed vector table, corner sequences, and random traffic vs a queue model.
module tb_lane_occupancy_tracker;
    import lane_occupancy_tracker_pkg::*;

    localparam int unsigned CNT_W = 4;
    localparam int unsigned DRAIN = 3;
    localparam int          CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lane_occupancy_tracker_if #(.CNT_W(CNT_W)) bus ();

    lane_occupancy_tracker #(
        .CNT_W        (CNT_W),
        .DRAIN_CYCLES (DRAIN)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: vehicles per lane, and how long the current one-hot grant has been held.
    int         m_cnt [1:8];
    bit [8:1]   m_ovf;
    bit         m_ill;
    int         m_run;
    logic [4:1] m_last;

    typedef struct {
        bit         r;
        logic [8:1] a;
        logic [4:1] t;
        bit         c;
        logic [8:1] sens;
        logic [8:1] ovf;
        bit         ill;
        int         lane;
        int         cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    function automatic int dut_count(input int l);
        logic [8*CNT_W-1:0] tmp;
        tmp = bus.queue_count >> ((l - 1) * CNT_W);
        return int'(tmp[CNT_W-1:0]);
    endfunction

    task automatic model_step(input bit r, input logic [8:1] a, input logic [4:1] t, input bit c);
        bit onehot;
        bit tick;
        bit d;
        bit s;
        if (r) begin
            for (int l = 1; l <= 8; l++) m_cnt[l] = 0;
            m_ovf  = '0;
            m_ill  = 1'b0;
            m_run  = 0;
            m_last = '0;
            return;
        end
        onehot = ($countones(t) == 1);
        if (onehot) m_run = (t == m_last) ? m_run + 1 : 1;
        else        m_run = 0;
        tick   = onehot && ((m_run % DRAIN) == 0);
        m_last = t;
        m_ill  = (t != 0) && !onehot;
        for (int l = 1; l <= 8; l++) begin
            d = tick && t[(l + 1) / 2] && (m_cnt[l] > 0);
            s = 1'b0;
            if (a[l] && !d) begin
                if (m_cnt[l] == CMAX) s = 1'b1;
                else                  m_cnt[l]++;
            end else if (!a[l] && d) begin
                m_cnt[l]--;
            end
            m_ovf[l] = s | (m_ovf[l] & !c);
        end
    endtask

    task automatic check_model();
        logic [8:1] exp_sens;
        for (int l = 1; l <= 8; l++) begin
            exp_sens[l] = (m_cnt[l] != 0);
            check($sformatf("model_count%0d", l), dut_count(l), m_cnt[l]);
        end
        check("model_sensors", int'(bus.sensors), int'(exp_sens));
        check("model_overflow", int'(bus.overflow), int'(m_ovf));
        check("model_illegal", int'(bus.illegal_grant), int'(m_ill));
    endtask

    task automatic cycle(input bit r, input logic [8:1] a, input logic [4:1] t, input bit c);
        rst         = r;
        bus.arrive  = a;
        bus.traffic = t;
        bus.ovf_clr = c;
        @(posedge clk);
        model_step(r, a, t, c);
        #1;
        check_model();
    endtask

    function automatic vec_t mk(input bit r, input logic [8:1] a, input logic [4:1] t,
                                input bit c, input logic [8:1] sens, input logic [8:1] ovf,
                                input bit ill, input int lane, input int cnt);
        vec_t v;
        v.r = r; v.a = a; v.t = t; v.c = c;
        v.sens = sens; v.ovf = ovf; v.ill = ill; v.lane = lane; v.cnt = cnt;
        return v;
    endfunction

    initial begin
        logic [8:1] ra;
        logic [4:1] rt;
        int         sel;

        // Reset, then a single arrival on lane 3.
        repeat (3) vecs.push_back(mk(1, 8'h00, 4'h0, 0, 8'h00, 8'h00, 0, 3, 0));
        vecs.push_back(mk(0, 8'h04, 4'h0, 0, 8'h04, 8'h00, 0, 3, 1));
        vecs.push_back(mk(0, 8'h00, 4'h0, 0, 8'h04, 8'h00, 0, 3, 1));
        // Load lane1=2, lane2=1, then drain under phase 1.
        vecs.push_back(mk(0, 8'h03, 4'h0, 0, 8'h07, 8'h00, 0, 1, 1));
        vecs.push_back(mk(0, 8'h01, 4'h0, 0, 8'h07, 8'h00, 0, 1, 2));
        vecs.push_back(mk(0, 8'h00, 4'h1, 0, 8'h07, 8'h00, 0, 1, 2));
        vecs.push_back(mk(0, 8'h00, 4'h1, 0, 8'h07, 8'h00, 0, 1, 2));
        vecs.push_back(mk(0, 8'h00, 4'h1, 0, 8'h05, 8'h00, 0, 2, 0));
        vecs.push_back(mk(0, 8'h00, 4'h1, 0, 8'h05, 8'h00, 0, 1, 1));
        vecs.push_back(mk(0, 8'h00, 4'h1, 0, 8'h05, 8'h00, 0, 1, 1));
        vecs.push_back(mk(0, 8'h00, 4'h1, 0, 8'h04, 8'h00, 0, 1, 0));
        vecs.push_back(mk(0, 8'h00, 4'h1, 0, 8'h04, 8'h00, 0, 2, 0));
        // Lane 5 with an interrupted grant.
        vecs.push_back(mk(0, 8'h10, 4'h0, 0, 8'h14, 8'h00, 0, 5, 1));
        vecs.push_back(mk(0, 8'h00, 4'h4, 0, 8'h14, 8'h00, 0, 5, 1));
        vecs.push_back(mk(0, 8'h00, 4'h4, 0, 8'h14, 8'h00, 0, 5, 1));
        vecs.push_back(mk(0, 8'h00, 4'h0, 0, 8'h14, 8'h00, 0, 5, 1));
        vecs.push_back(mk(0, 8'h00, 4'h4, 0, 8'h14, 8'h00, 0, 5, 1));
        vecs.push_back(mk(0, 8'h00, 4'h4, 0, 8'h14, 8'h00, 0, 5, 1));
        vecs.push_back(mk(0, 8'h00, 4'h4, 0, 8'h04, 8'h00, 0, 5, 0));
        // Multi-hot grant flags for one cycle only.
        vecs.push_back(mk(0, 8'h00, 4'h3, 0, 8'h04, 8'h00, 1, 3, 1));
        vecs.push_back(mk(0, 8'h00, 4'h0, 0, 8'h04, 8'h00, 0, 3, 1));

        foreach (vecs[i]) begin
            cycle(vecs[i].r, vecs[i].a, vecs[i].t, vecs[i].c);
            check($sformatf("tbl%0d_sensors", i), int'(bus.sensors), int'(vecs[i].sens));
            check($sformatf("tbl%0d_overflow", i), int'(bus.overflow), int'(vecs[i].ovf));
            check($sformatf("tbl%0d_illegal", i), int'(bus.illegal_grant), int'(vecs[i].ill));
            check($sformatf("tbl%0d_count%0d", i, vecs[i].lane), dut_count(vecs[i].lane),
                  vecs[i].cnt);
        end

        // Saturation on lane 8.
        repeat (15) cycle(0, 8'h80, 4'h0, 0);
        check("sat_count15", dut_count(8), 15);
        check("sat_no_ovf_yet", int'(bus.overflow[8]), 0);
        cycle(0, 8'h80, 4'h0, 0);
        check("sat_count_hold", dut_count(8), 15);
        check("sat_ovf_set", int'(bus.overflow[8]), 1);
        cycle(0, 8'h00, 4'h8, 0);
        cycle(0, 8'h00, 4'h8, 0);
        cycle(0, 8'h80, 4'h8, 0);
        check("sat_arrive_on_tick", dut_count(8), 15);
        cycle(0, 8'h00, 4'h0, 1);
        check("ovf_clr", int'(bus.overflow), 0);
        cycle(0, 8'h80, 4'h0, 1);
        check("ovf_set_wins", int'(bus.overflow[8]), 1);
        cycle(0, 8'h00, 4'h0, 1);
        check("ovf_clr_again", int'(bus.overflow[8]), 0);

        // Arrival coinciding with a tick on lane 1.
        cycle(0, 8'h01, 4'h0, 0);
        check("sim_load", dut_count(1), 1);
        cycle(0, 8'h00, 4'h1, 0);
        cycle(0, 8'h00, 4'h1, 0);
        cycle(0, 8'h01, 4'h1, 0);
        check("sim_arrive_tick", dut_count(1), 1);

        // Reset during an active grant, then a fresh interval.
        cycle(0, 8'h00, 4'h1, 0);
        cycle(1, 8'h00, 4'h1, 0);
        check("midrst_sensors", int'(bus.sensors), 0);
        check("midrst_count1", dut_count(1), 0);
        check("midrst_count8", dut_count(8), 0);
        cycle(0, 8'h01, 4'h1, 0);
        check("postrst_c1", dut_count(1), 1);
        cycle(0, 8'h00, 4'h1, 0);
        check("postrst_c2", dut_count(1), 1);
        cycle(0, 8'h00, 4'h1, 0);
        check("postrst_c3", dut_count(1), 0);

        // Random traffic against the model.
        rt = 4'h1;
        for (int n = 0; n < 3000; n++) begin
            ra  = 8'($urandom & $urandom);
            sel = $urandom_range(0, 9);
            if (sel == 6)      rt = 4'h0;
            else if (sel == 7) rt = 4'(1 << $urandom_range(0, 3));
            else if (sel == 8) rt = 4'($urandom);
            else if (sel == 9) rt = 4'(1 << $urandom_range(0, 3));
            cycle($urandom_range(0, 199) == 0, ra, rt, $urandom_range(0, 19) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
